mw_control: RTL and testbench
=============================

Name: mw_control

Overview:
- Front-panel control unit for the microwave, directly upstream of the countdown timer.
- Synchronises and debounces the keypad, start, stop and clear buttons, and the door switch.
- Turns key presses into digit-load pulses (data/loadn) and timer-clear pulses (tclrn).
- Gates counting (en) and the magnetron from a cook state machine; consumes the timer's zero flag to end cooking and sound the beeper.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a debounced level changes (>=2).
- BEEP_CYCLES, 8, number of cycles beep is held high in DONE (>=1).

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- keys  in  10  digit keys 0-9, active-high, bit i = digit i
- startn  in  1  start button, active-low
- stopn  in  1  stop button, active-low
- clearn  in  1  clear button, active-low
- door_closed  in  1  door switch, 1 = closed
- zero  in  1  timer reports 00:00
- data  out  4  digit for timer to shift in
- loadn  out  1  active-low, one-cycle digit load strobe to timer
- tclrn  out  1  active-low, one-cycle timer clear strobe
- en  out  1  timer count enable
- mag_on  out  1  magnetron drive
- beep  out  1  end-of-cook beeper
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (clrn=0, async): state=IDLE, data=0, loadn=1, tclrn=1, en=0, mag_on=0, beep=0; all synchroniser and debouncer flops are cleared to the "released/open" level.
- Input path, per button and per key:
  - 2-flop synchroniser, then debouncer.
  - The debounced level follows the synchronised level only after DEBOUNCE_CYCLES consecutive equal samples; a glitch shorter than that is discarded.
  - A press event is a one-cycle pulse on the debounced pressed-edge.
  - Latency: the event is visible at the FSM exactly 2+DEBOUNCE_CYCLES edges after the raw change; FSM outputs update on the following edge.
- door_closed is synchronised only (no debounce).
- Digit press is valid only if exactly one debounced key is pressed in that cycle; non-one-hot combinations are ignored.
- All strobe outputs are registered.
  - A digit load puts data=digit and loadn=0 for exactly one cycle; data holds its value afterwards.
  - tclrn=0 for exactly one cycle.
- Event priority when simultaneous: clear > stop > door open > start > digit.
- States (state_o encoding): IDLE=0, SET=1, COOK=2, PAUSED=3, DONE=4.
  - IDLE: digit -> load strobe, go SET. start ignored. clear -> tclrn strobe, stay IDLE.
  - SET: digit -> load strobe, stay SET. clear -> tclrn strobe, go IDLE. start with door_closed=1 and zero=0 -> COOK. start with door open or zero=1 is ignored.
  - COOK: en=1, mag_on=1.
    - zero=1 -> DONE.
    - stop, clear or door_closed=0 -> PAUSED.
    - Digits ignored.
  - PAUSED: en=0, mag_on=0. start with door_closed=1 and zero=0 -> COOK. stop or clear -> tclrn strobe, go IDLE. Digits ignored.
  - DONE: beep=1 for BEEP_CYCLES cycles, then IDLE. Any press event (key or button) cancels beep and goes IDLE; that event is consumed and has no other effect.
- en and mag_on are registered state decodes. Both deassert on the edge the FSM leaves COOK, i.e. one cycle after zero or door-open is seen.
- Door opening mid-COOK drops mag_on within 3 cycles of the raw change: 2 synchroniser cycles + 1 FSM cycle.
- Reset asserted mid-operation returns everything to reset values immediately. The timer is not cleared by this block; it shares clrn.

Decomposition:
- Shared package mw_pkg holds:
  - state encoding localparams;
  - default DEBOUNCE_CYCLES and BEEP_CYCLES;
  - the digit width constant (4).
- One sub-module, btn_debounce (parameters WIDTH and DEBOUNCE_CYCLES). It contains the synchroniser, debouncer and press-edge pulse for a vector of inputs, and is instantiated once for {keys, start, stop, clear} with WIDTH=13.
- The FSM and output registers live in mw_control.

Test Plan:
- Reset, then press key 9 then key 8, each held 10 cycles -> two loadn=0 single-cycle pulses with data=9 then data=8, state IDLE->SET, en=0.
- From SET with zero=0, door closed, pulse startn low 10 cycles -> state COOK, en=1, mag_on=1; bench drives zero=1 -> next edge en=0, beep=1 for 8 cycles, then state IDLE.
- During COOK, drop door_closed -> mag_on=0 within 3 cycles, state PAUSED; close door and press start -> COOK resumes; press stop twice -> PAUSED, then tclrn single pulse and IDLE.
- Key 3 glitch of 2 cycles, and keys 3+5 pressed together -> no loadn pulse, state unchanged.
- Press start in IDLE, or in SET with zero=1 -> no transition, en stays 0.
- Assert clrn=0 mid-COOK -> en, mag_on, beep low and state_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mw_pkg.sv
// Shared constants, state encoding and key decode helper for the microwave front panel.
// No timing of its own; consumed by mw_control and btn_debounce.
// No flow control: pure declarations.
package mw_pkg;

  localparam int DIGIT_W              = 4;
  localparam int NUM_KEYS             = 10;
  localparam int BTN_W                = NUM_KEYS + 3;
  localparam int START_IDX            = NUM_KEYS;
  localparam int STOP_IDX             = NUM_KEYS + 1;
  localparam int CLEAR_IDX            = NUM_KEYS + 2;
  localparam int DEBOUNCE_CYCLES_DEF  = 4;
  localparam int BEEP_CYCLES_DEF      = 8;

  // Debounced vector bits that belong to the digit keys.
  localparam logic [BTN_W-1:0] KEY_MASK = {{(BTN_W-NUM_KEYS){1'b0}}, {NUM_KEYS{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_COOK   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Index of the (single) set key bit; only meaningful when the key field is one-hot.
  function automatic logic [DIGIT_W-1:0] key_to_digit(input logic [BTN_W-1:0] k);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and press-edge detector for a vector of active-high pressed levels.
// Latency: press pulse and new level appear 2+DEBOUNCE_CYCLES edges after the raw change.
// No backpressure: press is a one-cycle pulse that must be consumed when it appears.
module btn_debounce #(
  parameter int WIDTH           = 13,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];

  // Two-flop synchroniser; released level is 0.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-bit run counter: level flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      level <= '0;
      press <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          level[i] <= sync2[i];
          press[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mw_control.sv
// Microwave front-panel control: debounced inputs drive the cook FSM and timer strobes.
// Latency: button/key to output is 3+DEBOUNCE_CYCLES edges; door-open to mag_on drop is 3 edges.
// No backpressure: the timer must accept loadn/tclrn strobes in the cycle they are issued.
module mw_control #(
  parameter int DEBOUNCE_CYCLES = mw_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int BEEP_CYCLES     = mw_pkg::BEEP_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic [mw_pkg::NUM_KEYS-1:0] keys,
  input  logic                       startn,
  input  logic                       stopn,
  input  logic                       clearn,
  input  logic                       door_closed,
  input  logic                       zero,
  output logic [mw_pkg::DIGIT_W-1:0] data,
  output logic                       loadn,
  output logic                       tclrn,
  output logic                       en,
  output logic                       mag_on,
  output logic                       beep,
  output logic [2:0]                 state_o
);

  import mw_pkg::*;

  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  logic [BTN_W-1:0] raw;
  logic [BTN_W-1:0] dbn_lvl;
  logic [BTN_W-1:0] dbn_press;
  logic [BTN_W-1:0] key_lvl;
  logic             door_s1;
  logic             door_s2;
  logic             digit_evt;
  logic             start_ok;
  logic             any_evt;
  logic [DIGIT_W-1:0] digit;
  logic [BW-1:0]    beep_cnt;
  state_t           state;

  // Buttons are active-low at the pins; the debouncer works on pressed=1.
  assign raw = {~clearn, ~stopn, ~startn, keys};

  btn_debounce #(
    .WIDTH           (BTN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dbn (
    .clk   (clk),
    .clrn  (clrn),
    .raw   (raw),
    .level (dbn_lvl),
    .press (dbn_press)
  );

  // Door switch only needs synchronising; reset level is "open".
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      door_s1 <= 1'b0;
      door_s2 <= 1'b0;
    end else begin
      door_s1 <= door_closed;
      door_s2 <= door_s1;
    end
  end

  // A key press counts only while exactly one key is held down.
  assign key_lvl   = dbn_lvl & KEY_MASK;
  assign digit_evt = (|(dbn_press & KEY_MASK)) && $onehot(key_lvl);
  assign digit     = key_to_digit(key_lvl);
  assign start_ok  = dbn_press[START_IDX] && door_s2 && !zero;
  assign any_evt   = |dbn_press;
  assign state_o   = state;

  // Cook FSM with registered strobes and state-decoded enables.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      data     <= '0;
      loadn    <= 1'b1;
      tclrn    <= 1'b1;
      en       <= 1'b0;
      mag_on   <= 1'b0;
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else begin
      loadn <= 1'b1;
      tclrn <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (dbn_press[CLEAR_IDX]) begin
            tclrn <= 1'b0;
          end else if (digit_evt) begin
            data  <= digit;
            loadn <= 1'b0;
            state <= ST_SET;
          end
        end
        ST_SET: begin
          if (dbn_press[CLEAR_IDX]) begin
            tclrn <= 1'b0;
            state <= ST_IDLE;
          end else if (start_ok) begin
            state  <= ST_COOK;
            en     <= 1'b1;
            mag_on <= 1'b1;
          end else if (digit_evt) begin
            data  <= digit;
            loadn <= 1'b0;
          end
        end
        ST_COOK: begin
          if (dbn_press[CLEAR_IDX] || dbn_press[STOP_IDX] || !door_s2) begin
            state  <= ST_PAUSED;
            en     <= 1'b0;
            mag_on <= 1'b0;
          end else if (zero) begin
            state    <= ST_DONE;
            en       <= 1'b0;
            mag_on   <= 1'b0;
            beep     <= 1'b1;
            beep_cnt <= '0;
          end
        end
        ST_PAUSED: begin
          if (dbn_press[CLEAR_IDX] || dbn_press[STOP_IDX]) begin
            tclrn <= 1'b0;
            state <= ST_IDLE;
          end else if (start_ok) begin
            state  <= ST_COOK;
            en     <= 1'b1;
            mag_on <= 1'b1;
          end
        end
        ST_DONE: begin
          // Any press just silences the beeper; it is not acted on further.
          if (any_evt || beep_cnt == BEEP_LAST) begin
            beep  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            beep_cnt <= beep_cnt + BW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          en     <= 1'b0;
          mag_on <= 1'b0;
          beep   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mw_control.sv
// Self-checking bench for mw_control: vector table plus hand-written multi-cycle sequences.
// Loaded digits are checked through a scoreboard queue popped on each loadn strobe.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mw_control;

  logic       clk = 1'b0;
  logic       clrn;
  logic [9:0] keys;
  logic       startn, stopn, clearn;
  logic       door_closed, zero;
  logic [3:0] data;
  logic       loadn, tclrn, en, mag_on, beep;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];
  int tclr_seen = 0;
  int exp_tclr  = 0;
  logic prev_loadn = 1'b1;
  logic prev_tclrn = 1'b1;

  localparam int K_KEY = 0, K_COMBO = 1, K_START = 2, K_STOP = 3, K_CLEAR = 4;

  typedef struct {
    int   kind;
    int   arg;
    int   hold;
    logic zero;
    logic door;
    int   push;
    logic clr;
    int   st;
    logic en;
  } vec_t;

  vec_t tbl[11];

  mw_control dut (
    .clk         (clk),
    .clrn        (clrn),
    .keys        (keys),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .zero        (zero),
    .data        (data),
    .loadn       (loadn),
    .tclrn       (tclrn),
    .en          (en),
    .mag_on      (mag_on),
    .beep        (beep),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [9:0] mask, input int hold);
    keys = mask;
    tick(hold);
    keys = '0;
    tick(10);
  endtask

  task automatic press_btn(input int which, input int hold);
    if (which == K_START) startn = 1'b0;
    if (which == K_STOP)  stopn  = 1'b0;
    if (which == K_CLEAR) clearn = 1'b0;
    tick(hold);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
    tick(10);
  endtask

  // Strobe monitor: each load pops the scoreboard, every strobe must be one cycle wide.
  always @(negedge clk) begin
    if (clrn) begin
      if (!loadn) begin
        check("load_expected", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) check("load_data", int'(data), sb_q.pop_front());
        check("loadn_width", int'(prev_loadn), 1);
      end
      if (!tclrn) begin
        tclr_seen++;
        check("tclrn_width", int'(prev_tclrn), 1);
      end
    end
    prev_loadn = loadn;
    prev_tclrn = tclrn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    //         kind     arg   hold zero door push clr st en
    tbl[0]  = '{K_KEY,   8,    10, 1'b0, 1'b1, 8,  1'b0, 1, 1'b0};
    tbl[1]  = '{K_KEY,   3,    2,  1'b0, 1'b1, -1, 1'b0, 1, 1'b0};
    tbl[2]  = '{K_COMBO, 'h028, 10, 1'b0, 1'b1, -1, 1'b0, 1, 1'b0};
    tbl[3]  = '{K_START, 0,    10, 1'b1, 1'b1, -1, 1'b0, 1, 1'b0};
    tbl[4]  = '{K_START, 0,    10, 1'b0, 1'b0, -1, 1'b0, 1, 1'b0};
    tbl[5]  = '{K_STOP,  0,    10, 1'b0, 1'b1, -1, 1'b0, 1, 1'b0};
    tbl[6]  = '{K_CLEAR, 0,    10, 1'b0, 1'b1, -1, 1'b1, 0, 1'b0};
    tbl[7]  = '{K_START, 0,    10, 1'b0, 1'b1, -1, 1'b0, 0, 1'b0};
    tbl[8]  = '{K_CLEAR, 0,    10, 1'b0, 1'b1, -1, 1'b1, 0, 1'b0};
    tbl[9]  = '{K_KEY,   7,    10, 1'b0, 1'b1, 7,  1'b0, 1, 1'b0};
    tbl[10] = '{K_KEY,   0,    10, 1'b0, 1'b1, 0,  1'b0, 1, 1'b0};

    keys = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; zero = 1'b0;
    clrn = 1'b1;
    #1 clrn = 1'b0;
    tick(3);
    check("rst_state", int'(state_o), 0);
    check("rst_data", int'(data), 0);
    check("rst_loadn", int'(loadn), 1);
    check("rst_tclrn", int'(tclrn), 1);
    check("rst_en", int'(en), 0);
    check("rst_mag_on", int'(mag_on), 0);
    check("rst_beep", int'(beep), 0);
    clrn = 1'b1;
    tick(4);

    // Key 9: load strobe exactly 7 edges after the raw press.
    sb_q.push_back(9);
    keys = 10'd1 << 9;
    tick(6);
    check("k9_loadn_early", int'(loadn), 1);
    tick(1);
    check("k9_loadn_on_time", int'(loadn), 0);
    check("k9_state", int'(state_o), 1);
    tick(3);
    keys = '0;
    tick(10);

    for (int r = 0; r < 11; r++) begin
      zero = tbl[r].zero;
      door_closed = tbl[r].door;
      tick(4);
      if (tbl[r].push >= 0) sb_q.push_back(tbl[r].push);
      if (tbl[r].clr) exp_tclr++;
      case (tbl[r].kind)
        K_KEY:   press_key(10'(1 << tbl[r].arg), tbl[r].hold);
        K_COMBO: press_key(10'(tbl[r].arg), tbl[r].hold);
        default: press_btn(tbl[r].kind, tbl[r].hold);
      endcase
      check($sformatf("vec%0d_state", r), int'(state_o), tbl[r].st);
      check($sformatf("vec%0d_en", r), int'(en), int'(tbl[r].en));
      check($sformatf("vec%0d_tclrn_count", r), tclr_seen, exp_tclr);
    end

    // Cook to completion: start latency, zero ends cook, 8-cycle beep then IDLE.
    zero = 1'b0; door_closed = 1'b1;
    tick(4);
    startn = 1'b0;
    tick(6);
    check("start_not_yet", int'(state_o), 1);
    tick(1);
    check("cook_state", int'(state_o), 2);
    check("cook_en", int'(en), 1);
    check("cook_mag", int'(mag_on), 1);
    startn = 1'b1;
    tick(10);
    zero = 1'b1;
    tick(1);
    check("done_en", int'(en), 0);
    check("done_mag", int'(mag_on), 0);
    check("done_state", int'(state_o), 4);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (beep) bc++;
      tick(1);
    end
    check("beep_cycles", bc, 8);
    check("beep_off", int'(beep), 0);
    check("after_done_state", int'(state_o), 0);
    zero = 1'b0;
    tick(2);

    // Door open mid-cook, resume, then stop twice.
    sb_q.push_back(5);
    press_key(10'd1 << 5, 10);
    press_btn(K_START, 10);
    check("cook2_en", int'(en), 1);
    door_closed = 1'b0;
    tick(3);
    check("door_mag_off", int'(mag_on), 0);
    check("door_paused", int'(state_o), 3);
    check("door_en_off", int'(en), 0);
    door_closed = 1'b1;
    tick(4);
    press_btn(K_START, 10);
    check("resume_state", int'(state_o), 2);
    check("resume_mag", int'(mag_on), 1);
    press_btn(K_STOP, 10);
    check("stop1_state", int'(state_o), 3);
    check("stop1_en", int'(en), 0);
    exp_tclr++;
    press_btn(K_STOP, 10);
    check("stop2_state", int'(state_o), 0);
    check("stop2_tclrn_count", tclr_seen, exp_tclr);

    // Asynchronous reset mid-cook.
    sb_q.push_back(2);
    press_key(10'd1 << 2, 10);
    press_btn(K_START, 10);
    check("cook3_mag", int'(mag_on), 1);
    #2 clrn = 1'b0;
    #1;
    check("arst_en", int'(en), 0);
    check("arst_mag", int'(mag_on), 0);
    check("arst_beep", int'(beep), 0);
    check("arst_state", int'(state_o), 0);
    check("arst_data", int'(data), 0);
    tick(2);
    clrn = 1'b1;
    tick(5);
    check("post_rst_state", int'(state_o), 0);
    check("post_rst_tclrn_count", tclr_seen, exp_tclr);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
